// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_pkg
//  Description : Shared types for the two-lane stream demultiplexer.
//                Names the lane-select encoding so the top level can
//                compare against symbolic lane identifiers instead of
//                bare 0/1 literals.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

   // Destination-lane encoding carried on in_sel.
   typedef enum logic {
      LANE_0 = 1'b0,
      LANE_1 = 1'b1
   } lane_sel_e;

   localparam int c_NUM_LANES = 2;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_demux_lane.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux_lane
//  Description : One output lane of the stream demultiplexer: a single
//                N-bit holding register with a valid flag, drain detection
//                and a saturating delivered-word counter.
//  Ports       : clk           - clock, rising edge
//                rst           - synchronous active-high reset
//                i_wr_en       - load i_wr_data into the lane this cycle
//                i_wr_data     - word to load
//                i_ready       - downstream accept for this lane
//                o_valid       - lane register holds a word
//                o_data        - lane register contents
//                o_cnt         - delivered-word count (saturating)
//                o_can_accept  - lane is empty or is being drained now
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_lane #(
   parameter int N  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_wr_en,
   input  logic [N-1:0]  i_wr_data,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [N-1:0]  o_data,
   output logic [CW-1:0] o_cnt,
   output logic          o_can_accept
);

   logic          r_valid;
   logic [N-1:0]  r_data;
   logic [CW-1:0] r_cnt;

   logic          w_drain;
   logic          w_cnt_max;

   assign w_drain   = r_valid & i_ready;
   assign w_cnt_max = (r_cnt == {CW{1'b1}});

   // A lane being drained this cycle frees its register in time for a
   // same-cycle reload, giving one word per cycle throughput.
   assign o_can_accept = ~r_valid | w_drain;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         // A load wins over a drain so the valid flag stays set on reload;
         // on a plain drain only the flag clears and the data is held.
         if (i_wr_en) begin
            r_valid <= 1'b1;
            r_data  <= i_wr_data;
         end else if (w_drain) begin
            r_valid <= 1'b0;
         end

         if (w_drain && !w_cnt_max) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_cnt   = r_cnt;

endmodule : stream_demux_lane
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : stream_demux
//  Description : 1-to-2 valid/ready stream demultiplexer. Each accepted
//                upstream word is steered to the lane chosen by in_sel and
//                appears on that lane one cycle later. Each lane has its
//                own single-word register and delivered-word counter, so a
//                stalled lane never blocks the other.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                in_valid/in_data/in_sel  - upstream word and destination
//                in_ready                 - upstream accept
//                out0_valid/out0_data     - lane 0 output
//                out0_ready               - lane 0 downstream accept
//                out1_valid/out1_data     - lane 1 output
//                out1_ready               - lane 1 downstream accept
//                cnt0, cnt1               - per-lane delivered-word counts
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   input  logic          in_sel,
   output logic          in_ready,
   output logic          out0_valid,
   output logic [N-1:0]  out0_data,
   input  logic          out0_ready,
   output logic          out1_valid,
   output logic [N-1:0]  out1_data,
   input  logic          out1_ready,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1
);

   lane_sel_e    w_sel;
   logic [N-1:0] w_lane1_cand;
   logic [N-1:0] w_lane0_cand;
   logic         w_accept0;
   logic         w_accept1;
   logic         w_xfer;
   logic         w_wr0;
   logic         w_wr1;

   assign w_sel = lane_sel_e'(in_sel);

   // Lane data is formed with a mask rather than a mux: lane 1 sees the
   // word only when in_sel=1, and lane 0 sees the remainder via XOR. Only
   // the selected lane's write enable fires, so the zeroed candidate on
   // the other lane is never stored.
   assign w_lane1_cand = in_data & {N{in_sel}};
   assign w_lane0_cand = in_data ^ w_lane1_cand;

   assign in_ready = (w_sel == LANE_1) ? w_accept1 : w_accept0;
   assign w_xfer   = in_valid & in_ready;
   assign w_wr0    = w_xfer & (w_sel == LANE_0);
   assign w_wr1    = w_xfer & (w_sel == LANE_1);

   stream_demux_lane #(
      .N  (N),
      .CW (CW)
   ) u_lane0 (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (w_wr0),
      .i_wr_data    (w_lane0_cand),
      .i_ready      (out0_ready),
      .o_valid      (out0_valid),
      .o_data       (out0_data),
      .o_cnt        (cnt0),
      .o_can_accept (w_accept0)
   );

   stream_demux_lane #(
      .N  (N),
      .CW (CW)
   ) u_lane1 (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (w_wr1),
      .i_wr_data    (w_lane1_cand),
      .i_ready      (out1_ready),
      .o_valid      (out1_valid),
      .o_data       (out1_data),
      .o_cnt        (cnt1),
      .o_can_accept (w_accept1)
   );

endmodule : stream_demux
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_demux
//  Description : Self-checking bench for stream_demux (N=8, CW=4). Directed
//                scenarios plus randomized traffic, compared against a
//                per-lane behavioural model of occupancy, contents and
//                delivered counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

   localparam int N      = 8;
   localparam int CW     = 4;
   localparam int CNTMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_sel;
   logic          in_ready;
   logic          out0_valid, out1_valid;
   logic [N-1:0]  out0_data, out1_data;
   logic          out0_ready, out1_ready;
   logic [CW-1:0] cnt0, cnt1;

   int tests = 0;
   int fails = 0;

   // Behavioural model: what each lane currently holds and has delivered.
   bit      m_full [2];
   int      m_word [2];
   int      m_count[2];

   stream_demux #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_ready   (in_ready),
      .out0_valid (out0_valid),
      .out0_data  (out0_data),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_data  (out1_data),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_ready();
      int s = int'(in_sel);
      return !m_full[s] || (s == 0 ? out0_ready : out1_ready);
   endfunction

   // One clock: check in_ready mid-cycle, advance the model on the edge,
   // then check all lane outputs just after the edge.
   task automatic cycle();
      bit exp_rdy;
      bit rdy[2];
      @(negedge clk);
      exp_rdy = model_ready();
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      @(posedge clk);
      rdy[0] = out0_ready;
      rdy[1] = out1_ready;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_word[k] = 0; m_count[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            bit drain = m_full[k] && rdy[k];
            bit load  = in_valid && exp_rdy && (int'(in_sel) == k);
            if (drain) m_count[k] = (m_count[k] < CNTMAX) ? m_count[k] + 1 : CNTMAX;
            if (load) begin
               m_full[k] = 1; m_word[k] = int'(in_data);
            end else if (drain) begin
               m_full[k] = 0;
            end
         end
      end
      #1;
      chk("out0_valid", {31'b0, out0_valid}, {31'b0, m_full[0]});
      chk("out1_valid", {31'b0, out1_valid}, {31'b0, m_full[1]});
      chk("out0_data",  32'(out0_data), m_word[0]);
      chk("out1_data",  32'(out1_data), m_word[1]);
      chk("cnt0",       32'(cnt0), m_count[0]);
      chk("cnt1",       32'(cnt1), m_count[1]);
   endtask

   task automatic drive(input bit v, input bit s, input logic [N-1:0] d,
                        input bit r0, input bit r1);
      in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, '0, 0, 0);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_full[k] = 0; m_word[k] = 0; m_count[k] = 0;
      end
      #1;
      rst = 1'b0;
   endtask

   task automatic single_transfer_check();
      drive(1, 1, 8'hA5, 0, 0);
      cycle();
      chk("single_out1_valid", {31'b0, out1_valid}, 32'd1);
      chk("single_out1_data",  32'(out1_data), 32'hA5);
      chk("single_out0_valid", {31'b0, out0_valid}, 32'd0);
      chk("single_out0_data",  32'(out0_data), 32'h00);
   endtask

   initial begin
      int c1_before;
      rst = 1'b1;
      drive(0, 0, '0, 0, 0);

      // Reset and reset state.
      do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_valid0", {31'b0, out0_valid}, 32'd0);
      chk("rst_cnt0",   32'(cnt0), 32'd0);

      // Single transfer to lane 1 after reset.
      single_transfer_check();

      // Drain lane 1.
      drive(0, 0, '0, 0, 1);
      cycle();

      // Back-to-back stream 01..04 into lane 0 with continuous drain.
      for (int i = 1; i <= 4; i++) begin
         drive(1, 0, 8'(i), 1, 0);
         cycle();
         chk("stream_data", 32'(out0_data), i);
      end
      drive(0, 0, '0, 1, 0);
      cycle();
      chk("stream_cnt0", 32'(cnt0), 32'd4);

      // Blocking on a full lane, not blocking the other lane.
      drive(1, 0, 8'h11, 0, 0);
      cycle();
      drive(1, 0, 8'h22, 0, 0);
      #1;
      chk("block_ready", {31'b0, in_ready}, 32'd0);
      cycle();
      chk("block_data", 32'(out0_data), 32'h11);
      drive(1, 1, 8'h33, 0, 0);
      #1;
      chk("other_ready", {31'b0, in_ready}, 32'd1);
      cycle();
      chk("other_data", 32'(out1_data), 32'h33);

      // Same-cycle drain and reload on lane 1.
      drive(1, 1, 8'h3C, 0, 1);
      cycle();
      c1_before = int'(cnt1);
      drive(1, 1, 8'hC3, 0, 1);
      cycle();
      chk("reload_valid", {31'b0, out1_valid}, 32'd1);
      chk("reload_data",  32'(out1_data), 32'hC3);
      chk("reload_cnt1",  32'(cnt1), c1_before + 1);

      // Counter saturation: 20 drains on lane 0.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 8'($urandom), 1, 0);
         cycle();
      end
      drive(0, 0, '0, 1, 0);
      cycle();
      chk("sat_cnt0", 32'(cnt0), 32'hF);

      // Reset mid-operation with both lanes full and cnt0=3.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 8'(8'h40 + i), 1, 0);
         cycle();
      end
      drive(1, 0, 8'h5A, 1, 0);
      cycle();
      drive(1, 1, 8'h6B, 0, 0);
      cycle();
      chk("pre_rst_cnt0", 32'(cnt0), 32'd3);
      rst = 1'b1;
      drive(1, 0, 8'h77, 1, 1);
      cycle();
      rst = 1'b0;
      chk("mid_rst_v0", {31'b0, out0_valid}, 32'd0);
      chk("mid_rst_v1", {31'b0, out1_valid}, 32'd0);
      chk("mid_rst_d0", 32'(out0_data), 32'd0);
      chk("mid_rst_d1", 32'(out1_data), 32'd0);
      chk("mid_rst_c0", 32'(cnt0), 32'd0);
      chk("mid_rst_c1", 32'(cnt1), 32'd0);
      single_transfer_check();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
               8'($urandom), bit'($urandom_range(0, 2) != 0),
               bit'($urandom_range(0, 2) != 0));
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_stream_demux
`default_nettype wire
